pwm_multichannel_shadowed: RTL and testbench

//   NUM_CH-channel PWM generator. It sits between the SPI register file and the uo_out/uio_out pads.
//   It generalises the fixed 16-channel, 8-bit, 1-duty peripheral as follows:
//   - per-channel duty; programmable period and prescaler
//   - edge- or centre-aligned counting
//   - double-buffered (shadow) settings, committed only at a period boundary (glitch-free)

---
 rtl/pwm_multichannel_shadowed.sv | 153 +++++++++++++++
 tb/tb_pwm_multichannel_shadowed.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multichannel_shadowed.sv
// ---------------------------------------------------------------------------
// pwm_multichannel_shadowed
//
// Multi-channel PWM generator with a shared prescaled counter, per-channel
// duty, programmable period, edge- or centre-aligned counting, and
// double-buffered (shadow) settings that take effect only at a period
// boundary so a running waveform never glitches.
//
// Ports:
//   clk           system clock, all state on the rising edge
//   rst           asynchronous reset, active-high
//   en_out        per-channel output enable (0 forces the pin low)
//   en_pwm        per-channel mode: 1 = PWM, 0 = static high
//   duty          channel i duty = duty[i*CNT_W +: CNT_W] (shadowed)
//   period        counter top value P (shadowed)
//   center_mode   0 = edge-aligned, 1 = centre-aligned (shadowed)
//   prescale      counter advances every prescale+1 clocks (live)
//   load          one-clock request to commit duty/period/center_mode
//   out           registered PWM pins
//   cycle_start   one-clock pulse when the counter enters 0
//   load_pending  commit requested but not yet performed
// ---------------------------------------------------------------------------
module pwm_multichannel_shadowed #(
    parameter int NUM_CH  = 16,
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         en_out,
    input  logic [NUM_CH-1:0]         en_pwm,
    input  logic [NUM_CH*CNT_W-1:0]   duty,
    input  logic [CNT_W-1:0]          period,
    input  logic                      center_mode,
    input  logic [PRESC_W-1:0]        prescale,
    input  logic                      load,
    output logic [NUM_CH-1:0]         out,
    output logic                      cycle_start,
    output logic                      load_pending
);

    // Slope the current counter value belongs to. In centre mode the value P
    // is the first value of the down slope and 0 the first of the up slope.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [PRESC_W-1:0]       presc_cnt;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_nxt;
    dir_t                     dir;
    dir_t                     dir_nxt;

    logic [NUM_CH*CNT_W-1:0]  duty_sh;
    logic [CNT_W-1:0]         period_sh;
    logic                     mode_sh;

    logic                     tick;
    logic                     boundary;
    logic                     commit;
    logic [NUM_CH-1:0]        pwm;

    // Prescaler: a prescale lowered below presc_cnt simply lets presc_cnt
    // run on and wrap before the next match.
    assign tick     = (presc_cnt == prescale);
    assign boundary = tick && (cnt_nxt == '0);
    assign commit   = boundary && (load_pending || load);

    // Next counter value and slope, applied only on a tick.
    // NOTE: every variable assigned in an always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_nxt = cnt;
        dir_nxt = dir;
        if (period_sh == '0) begin
            cnt_nxt = '0;
            dir_nxt = DIR_UP;
        end else if (!mode_sh) begin
            cnt_nxt = (cnt >= period_sh) ? '0 : cnt + 1'b1;
            dir_nxt = DIR_UP;
        end else if (dir == DIR_UP) begin
            if (cnt >= period_sh) begin
                // Only reachable if the counter overshot P; head back down.
                cnt_nxt = cnt - 1'b1;
                dir_nxt = DIR_DOWN;
            end else begin
                cnt_nxt = cnt + 1'b1;
                if (cnt_nxt == period_sh)
                    dir_nxt = DIR_DOWN;
            end
        end else begin
            cnt_nxt = (cnt == '0) ? '0 : cnt - 1'b1;
            if (cnt_nxt == '0)
                dir_nxt = DIR_UP;
        end
    end

    // Compare stage. Edge mode: high while cnt < duty. Centre mode: the down
    // slope compares inclusively so the high time is exactly 2*duty ticks,
    // centred on cnt = 0, and any duty >= P gives a constant high.
    always_comb begin
        pwm = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mode_sh && (dir == DIR_DOWN))
                pwm[i] = (cnt <= duty_sh[i*CNT_W +: CNT_W]);
            else
                pwm[i] = (cnt <  duty_sh[i*CNT_W +: CNT_W]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values and evaluation order is irrelevant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_cnt    <= '0;
            cnt          <= '0;
            dir          <= DIR_UP;
            // NOTE: the shadow registers hold the active configuration, so
            // they are reset like any other control state rather than left
            // uninitialised as a plain storage array would be.
            duty_sh      <= '0;
            period_sh    <= '0;
            mode_sh      <= 1'b0;
            load_pending <= 1'b0;
            cycle_start  <= 1'b0;
            out          <= '0;
        end else begin
            presc_cnt   <= tick ? '0 : presc_cnt + 1'b1;
            cycle_start <= boundary;

            if (tick) begin
                cnt <= cnt_nxt;
                dir <= dir_nxt;
            end

            // The commit shares the edge on which cnt returns to 0, so the new
            // settings govern the whole of the next period.
            if (commit) begin
                duty_sh      <= duty;
                period_sh    <= period;
                mode_sh      <= center_mode;
                dir          <= DIR_UP;
                load_pending <= 1'b0;
            end else if (load) begin
                load_pending <= 1'b1;
            end

            out <= en_out & ((en_pwm & pwm) | ~en_pwm);
        end
    end

endmodule

// File: tb/tb_pwm_multichannel_shadowed.sv
// ---------------------------------------------------------------------------
// tb_pwm_multichannel_shadowed
//
// Directed bench for pwm_multichannel_shadowed. Expected per-clock values of
// cycle_start, load_pending and out are derived from the waveform definition
// (tick index within a period, high-time rule per mode) and queued; they are
// popped and compared on the falling edge while the DUT runs.
// ---------------------------------------------------------------------------
module tb_pwm_multichannel_shadowed;

    localparam int NUM_CH  = 16;
    localparam int CNT_W   = 8;
    localparam int PRESC_W = 8;

    logic                     clk;
    logic                     rst;
    logic [NUM_CH-1:0]        en_out;
    logic [NUM_CH-1:0]        en_pwm;
    logic [NUM_CH*CNT_W-1:0]  duty;
    logic [CNT_W-1:0]         period;
    logic                     center_mode;
    logic [PRESC_W-1:0]       prescale;
    logic                     load;
    logic [NUM_CH-1:0]        out;
    logic                     cycle_start;
    logic                     load_pending;

    typedef struct packed {
        logic              cs;
        logic              lp;
        logic [NUM_CH-1:0] o;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    pwm_multichannel_shadowed #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en_out       (en_out),
        .en_pwm       (en_pwm),
        .duty         (duty),
        .period       (period),
        .center_mode  (center_mode),
        .prescale     (prescale),
        .load         (load),
        .out          (out),
        .cycle_start  (cycle_start),
        .load_pending (load_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_duty(input int ch, input int v);
        duty[ch*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    task automatic pulse_load();
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Step at least one clock, then wait (bounded) for a cycle_start pulse.
    task automatic wait_cs(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (cycle_start !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(cycle_start), 32'd1);
    endtask

    // Pin level for tick index t of a period: edge mode high for the first
    // d ticks; centre mode high for d ticks either side of the cnt=0 tick.
    function automatic logic exp_pwm(input logic mode, input int p, input int d, input int t);
        if (!mode)
            return (t < d);
        return (t < d) || (t >= 2*p - d);
    endfunction

    function automatic int period_ticks(input logic mode, input int p);
        if (p == 0)
            return 1;
        return mode ? 2*p : p + 1;
    endfunction

    // Queue one period of expected values, starting at the cycle_start clock.
    // Clock j shows the pin level of the tick active at clock j-1, so clock 0
    // still reflects the previous period's last tick (and its duties).
    task automatic push_window(input logic mode, input int p, input int ps,
                               input logic [NUM_CH*CNT_W-1:0] dprev,
                               input logic [NUM_CH*CNT_W-1:0] dcur,
                               input int lp_lo, input int lp_hi);
        int   r;
        int   l;
        int   jp;
        int   t;
        logic [NUM_CH*CNT_W-1:0] dsel;
        exp_t e;
        r = period_ticks(mode, p);
        l = r * (ps + 1);
        for (int j = 0; j < l; j++) begin
            jp   = (j == 0) ? l - 1 : j - 1;
            t    = jp / (ps + 1);
            dsel = (j == 0) ? dprev : dcur;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                e.o[ch] = en_out[ch] &
                          (en_pwm[ch] ? exp_pwm(mode, p, int'(dsel[ch*CNT_W +: CNT_W]), t) : 1'b1);
            end
            e.cs = (j == 0);
            e.lp = (j >= lp_lo) && (j <= lp_hi);
            sb.push_back(e);
        end
    endtask

    task automatic drain(input string tag, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e = sb.pop_front();
            check($sformatf("%s[%0d].cycle_start", tag, i), 32'(cycle_start), 32'(e.cs));
            check($sformatf("%s[%0d].load_pending", tag, i), 32'(load_pending), 32'(e.lp));
            check($sformatf("%s[%0d].out", tag, i), 32'(out), 32'(e.o));
            @(negedge clk);
        end
    endtask

    logic [NUM_CH*CNT_W-1:0] d_old;
    logic [NUM_CH*CNT_W-1:0] d_new;

    initial begin
        rst         = 1'b1;
        en_out      = '1;
        en_pwm      = '1;
        duty        = '0;
        period      = '0;
        center_mode = 1'b0;
        prescale    = '0;
        load        = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_out", 32'(out), 32'd0);
        check("rst_cycle_start", 32'(cycle_start), 32'd0);
        check("rst_load_pending", 32'(load_pending), 32'd0);
        rst = 1'b0;

        // Edge mode: P=9, ch0 duty 3, ch1 duty 10 (>P), ch2 duty 9 (=P).
        period = 8'd9;
        set_duty(0, 3);
        set_duty(1, 10);
        set_duty(2, 9);
        pulse_load();
        // Reset shadow P=0 makes every tick a boundary: commit at once.
        check("edge_commit_cs", 32'(cycle_start), 32'd1);
        check("edge_commit_no_pending", 32'(load_pending), 32'd0);
        wait_cs("edge_sync");
        push_window(1'b0, 9, 0, duty, duty, -1, -2);
        push_window(1'b0, 9, 0, duty, duty, -1, -2);
        drain("edge", 20);

        // Shadowing: mid-period load, later live change wins at commit.
        wait_cs("shadow_sync");
        d_old = duty;
        set_duty(0, 7);
        d_new = duty;
        duty  = d_old;
        push_window(1'b0, 9, 0, d_old, d_old, 6, 9);
        push_window(1'b0, 9, 0, d_old, d_new, -1, -2);
        drain("shadow", 5);
        set_duty(0, 5);
        load = 1'b1;
        drain("shadow_ld", 1);
        load = 1'b0;
        drain("shadow_pend", 1);
        set_duty(0, 7);
        drain("shadow_rest", 13);

        // Load on the boundary clock commits that edge without pending.
        wait_cs("coinc_sync");
        d_old = duty;
        set_duty(0, 1);
        d_new = duty;
        duty  = d_old;
        push_window(1'b0, 9, 0, d_old, d_old, -1, -2);
        push_window(1'b0, 9, 0, d_old, d_new, -1, -2);
        drain("coinc", 9);
        set_duty(0, 1);
        load = 1'b1;
        drain("coinc_ld", 1);
        load = 1'b0;
        drain("coinc_rest", 10);

        // Asynchronous reset mid-run with an uncommitted load.
        wait_cs("arst_sync");
        repeat (3) @(negedge clk);
        set_duty(0, 9);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("arst_pending_before", 32'(load_pending), 32'd1);
        check("arst_out1_before", 32'(out[1]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_out", 32'(out), 32'd0);
        check("arst_cycle_start", 32'(cycle_start), 32'd0);
        check("arst_load_pending", 32'(load_pending), 32'd0);

        // Centre mode: P=4, prescale=1; ch1 duty 2, ch2 duty 4 (=P),
        // ch3 duty 9 (>P), ch4 duty 1, ch0 duty 0.
        @(negedge clk);
        rst         = 1'b0;
        prescale    = 8'd1;
        period      = 8'd4;
        center_mode = 1'b1;
        duty        = '0;
        set_duty(1, 2);
        set_duty(2, 4);
        set_duty(3, 9);
        set_duty(4, 1);
        @(negedge clk);
        check("arst_load_lost", 32'(load_pending), 32'd0);
        check("arst_out_after", 32'(out), 32'd0);
        @(negedge clk);
        pulse_load();
        check("centre_pending", 32'(load_pending), 32'd1);
        wait_cs("centre_commit");
        check("centre_commit_cleared", 32'(load_pending), 32'd0);
        wait_cs("centre_sync");
        push_window(1'b1, 4, 1, duty, duty, -1, -2);
        push_window(1'b1, 4, 1, duty, duty, -1, -2);
        drain("centre", 32);

        // Boundary values: duty 0, duty 255, static high, output disabled.
        rst = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        prescale    = 8'd0;
        period      = 8'd9;
        center_mode = 1'b0;
        duty        = '0;
        set_duty(1, 255);
        set_duty(2, 5);
        set_duty(3, 5);
        set_duty(4, 5);
        set_duty(5, 5);
        en_out      = 16'hFFE7;
        en_pwm      = 16'hFFEB;
        pulse_load();
        check("bound_commit_cs", 32'(cycle_start), 32'd1);
        wait_cs("bound_sync");
        push_window(1'b0, 9, 0, duty, duty, -1, -2);
        push_window(1'b0, 9, 0, duty, duty, -1, -2);
        drain("bound", 20);

        // P=0: every tick is a boundary; prescale=2 gives a tick every 3 clks.
        period   = 8'd0;
        prescale = 8'd2;
        pulse_load();
        check("p0_pending", 32'(load_pending), 32'd1);
        wait_cs("p0_commit");
        wait_cs("p0_sync");
        for (int k = 0; k < 4; k++)
            push_window(1'b0, 0, 2, duty, duty, -1, -2);
        drain("p0", 12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
